// File: rtl/run_sequencer_pkg.sv
// run_seq_pkg: sequencer state encoding and default parameter values shared by the run_sequencer slice
package run_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_FIN} seq_state_t;
  localparam int DEF_AW        = 8;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_LOAD_LEN  = 64;
  localparam int DEF_RES_BASE  = 64;
  localparam int DEF_RES_LEN   = 32;
  localparam int DEF_START_CYC = 2;
  localparam int DEF_TIMEOUT   = 4095;
endpackage

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: host-side bundle of the sequencer (go, load stream, data-memory port, core start/done, result stream, status)
// master = sequencer side, slave = host/core/memory side
interface run_sequencer_if import run_seq_pkg::*; #(
  parameter int AW = DEF_AW
) ();
  logic          go;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          mem_own;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          core_start;
  logic          core_done;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_ready;
  logic          busy;
  logic          timed_out;
  logic [15:0]   run_cycles;
  modport master (
    input  go, ld_valid, ld_data, mem_rdata, core_done, res_ready,
    output ld_ready, mem_own, mem_wr_en, mem_addr, mem_wdata, core_start,
           res_valid, res_data, busy, timed_out, run_cycles
  );
  modport slave (
    output go, ld_valid, ld_data, mem_rdata, core_done, res_ready,
    input  ld_ready, mem_own, mem_wr_en, mem_addr, mem_wdata, core_start,
           res_valid, res_data, busy, timed_out, run_cycles
  );
endinterface

// File: rtl/run_sequencer_beat_counter.sv
// beat_counter: AW+1-bit beat index with clear/enable and a last-beat flag against len
// ports: clk, rst_n (async low), clr (wins over en), en, len (1..2^AW), idx (low AW bits), last (current beat is len-th)
module beat_counter import run_seq_pkg::*; #(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [AW:0]   len,
  output logic [AW-1:0] idx,
  output logic          last
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [AW:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + ONE;
  assign idx  = cnt[AW-1:0];
  assign last = cnt == len - ONE;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: loads a byte image into core data memory, starts the core, times its run, then drains the result bytes
// ports: clk, rst_n (async low), bus (run_sequencer_if.master: go, ld_*, mem_*, core_start/done, res_*, busy, timed_out, run_cycles)
module run_sequencer import run_seq_pkg::*; #(
  parameter int AW        = DEF_AW,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int RES_BASE  = DEF_RES_BASE,
  parameter int RES_LEN   = DEF_RES_LEN,
  parameter int START_CYC = DEF_START_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  run_sequencer_if.master bus
);
  seq_state_t    state, nxt;
  logic [AW-1:0] idx;
  logic [AW:0]   len;
  logic          en, clr, last, done_ok, tmo;
  logic [15:0]   cyc_inc;
  // one counter serves load beats, start-hold cycles and drain beats
  assign len = state == S_LOAD  ? (AW+1)'(LOAD_LEN) :
               state == S_DRAIN ? (AW+1)'(RES_LEN)  : (AW+1)'(START_CYC);
  assign en  = state == S_LOAD  ? bus.ld_valid :
               state == S_DRAIN ? bus.res_ready : state == S_START;
  assign clr = state == S_IDLE || (en && last);
  beat_counter #(.AW(AW)) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .len  (len),
    .idx  (idx),
    .last (last)
  );
  assign cyc_inc = &bus.run_cycles ? bus.run_cycles : bus.run_cycles + 16'd1;
  // run_cycles is still 0 on the first RUN cycle, where done is not yet trusted
  assign done_ok = bus.core_done && bus.run_cycles != 16'd0;
  assign tmo     = cyc_inc == 16'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = bus.go ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = en && last ? S_START : S_LOAD;
      S_START: nxt = last ? S_RUN : S_START;
      S_RUN:   nxt = done_ok || tmo ? S_DRAIN : S_RUN;
      S_DRAIN: nxt = en && last ? S_FIN : S_DRAIN;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.run_cycles <= '0;
      bus.timed_out  <= 1'b0;
    end else if (state == S_IDLE && bus.go) begin
      bus.run_cycles <= '0;
      bus.timed_out  <= 1'b0;
    end else if (state == S_RUN) begin
      bus.run_cycles <= cyc_inc;
      if (tmo && !done_ok) bus.timed_out <= 1'b1;
    end
  assign bus.ld_ready   = state == S_LOAD;
  assign bus.mem_wr_en  = state == S_LOAD && bus.ld_valid;
  assign bus.mem_addr   = state == S_DRAIN ? AW'(RES_BASE) + idx : AW'(LOAD_BASE) + idx;
  assign bus.mem_wdata  = bus.ld_data;
  assign bus.mem_own    = state != S_RUN;
  assign bus.core_start = state != S_RUN && state != S_DRAIN;
  assign bus.res_valid  = state == S_DRAIN;
  assign bus.res_data   = bus.mem_rdata;
  assign bus.busy       = state != S_IDLE;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: per-cycle expected trace built from the sequencing rules, compared against run_sequencer every cycle
module tb_run_sequencer;
  localparam int AW = 8, LB = 0, LL = 4, RB = 64, RL = 2, SC = 2, TO = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  run_sequencer_if #(.AW(AW)) bus ();
  run_sequencer #(
    .AW(AW), .LOAD_BASE(LB), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL),
    .START_CYC(SC), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  logic [7:0] mem [256];
  logic [7:0] rmem [256];
  assign bus.mem_rdata = (int'(bus.mem_addr) >= RB && int'(bus.mem_addr) < RB + RL) ?
                         rmem[bus.mem_addr] : mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en && bus.mem_own) mem[bus.mem_addr] <= bus.mem_wdata;
  typedef struct {
    logic go, ld_valid, core_done, res_ready;
    logic [7:0] ld_data;
  } stim_t;
  typedef struct {
    logic ld_ready, mem_wr_en, mem_own, core_start, res_valid, busy, timed_out, ck_addr;
    logic [7:0] mem_addr, mem_wdata, res_data;
    logic [15:0] run_cycles;
  } exp_t;
  stim_t sq[$];
  exp_t eq[$], cmpq[$];
  exp_t ce;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] last_rc = '0;
  logic last_to = 1'b0;
  logic [7:0] ld_bytes [LL];
  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic exp_t mk(input logic busy, input logic cs, input logic own,
                              input logic [15:0] rc, input logic to);
    exp_t e;
    e = '{default: 0};
    e.busy = busy; e.core_start = cs; e.mem_own = own; e.run_cycles = rc; e.timed_out = to;
    return e;
  endfunction
  always @(negedge clk) if (cmpq.size() > 0) begin
    ce = cmpq.pop_front();
    chk("ld_ready", bus.ld_ready, ce.ld_ready);
    chk("mem_wr_en", bus.mem_wr_en, ce.mem_wr_en);
    chk("mem_own", bus.mem_own, ce.mem_own);
    chk("core_start", bus.core_start, ce.core_start);
    chk("res_valid", bus.res_valid, ce.res_valid);
    chk("busy", bus.busy, ce.busy);
    chk("timed_out", bus.timed_out, ce.timed_out);
    chk("run_cycles", bus.run_cycles, ce.run_cycles);
    if (ce.ck_addr) chk("mem_addr", bus.mem_addr, ce.mem_addr);
    if (ce.mem_wr_en) chk("mem_wdata", bus.mem_wdata, ce.mem_wdata);
    if (ce.res_valid) chk("res_data", bus.res_data, ce.res_data);
  end
  // one whole sequence: go, load with stalls, start hold, run until done/timeout, drain with stalls, fin, one idle cycle
  task automatic build(input bit dir_bytes, input int lpct, input int rpct, input bit [7:0] rpat,
                       input bit use_pat, input bit early, input int done_at);
    stim_t s;
    exp_t e;
    int i, k, j, m;
    bit dn, tmo;
    sq.delete();
    eq.delete();
    for (int b = 0; b < LL; b++) ld_bytes[b] = dir_bytes ? 8'(17 * (b + 1)) : 8'($urandom);
    for (int b = 0; b < RL; b++) rmem[RB + b] = 8'($urandom);
    s = '{default: 0};
    s.go = 1'b1;
    e = mk(0, 1, 1, last_rc, last_to);
    e.ck_addr = 1'b1; e.mem_addr = 8'(LB);
    sq.push_back(s); eq.push_back(e);
    i = 0;
    while (i < LL) begin
      s.go = 1'($urandom_range(1)); s.core_done = 1'($urandom_range(1)); s.res_ready = 1'($urandom_range(1));
      s.ld_valid = $urandom_range(99) >= lpct;
      s.ld_data = s.ld_valid ? ld_bytes[i] : 8'($urandom);
      e = mk(1, 1, 1, 0, 0);
      e.ld_ready = 1'b1; e.mem_wr_en = s.ld_valid; e.ck_addr = 1'b1;
      e.mem_addr = 8'(LB + i); e.mem_wdata = s.ld_data;
      sq.push_back(s); eq.push_back(e);
      if (s.ld_valid) i++;
    end
    for (int c = 0; c < SC; c++) begin
      s.go = 1'($urandom_range(1)); s.ld_valid = 1'($urandom_range(1)); s.core_done = 1'($urandom_range(1));
      sq.push_back(s); eq.push_back(mk(1, 1, 1, 0, 0));
    end
    s.ld_valid = 1'b0;
    k = 0;
    do begin
      k++;
      dn = (early && k == 1) || (done_at > 0 && k >= done_at);
      s.core_done = dn; s.go = 1'($urandom_range(1)); s.res_ready = 1'($urandom_range(1));
      sq.push_back(s); eq.push_back(mk(1, 0, 0, 16'(k - 1), 0));
    end while (!((k >= 2 && dn) || k == TO));
    tmo = !(k >= 2 && dn);
    j = 0; m = 0;
    while (j < RL) begin
      s.go = 1'($urandom_range(1)); s.core_done = 1'($urandom_range(1));
      s.res_ready = use_pat ? (m < 8 ? rpat[m] : 1'b1) : $urandom_range(99) >= rpct;
      e = mk(1, 0, 1, 16'(k), tmo);
      e.res_valid = 1'b1; e.ck_addr = 1'b1; e.mem_addr = 8'(RB + j); e.res_data = rmem[RB + j];
      sq.push_back(s); eq.push_back(e);
      if (s.res_ready) j++;
      m++;
    end
    s.go = 1'($urandom_range(1)); s.res_ready = 1'($urandom_range(1));
    sq.push_back(s); eq.push_back(mk(1, 1, 1, 16'(k), tmo));
    s = '{default: 0};
    e = mk(0, 1, 1, 16'(k), tmo);
    e.ck_addr = 1'b1; e.mem_addr = 8'(LB);
    sq.push_back(s); eq.push_back(e);
    last_rc = 16'(k);
    last_to = tmo;
  endtask
  task automatic drive(input stim_t s);
    bus.go = s.go; bus.ld_valid = s.ld_valid; bus.ld_data = s.ld_data;
    bus.core_done = s.core_done; bus.res_ready = s.res_ready;
  endtask
  task automatic play(input int n);
    stim_t idle;
    idle = '{default: 0};
    for (int p = 0; p < n; p++) begin
      @(posedge clk); #1;
      drive(sq[p]);
      cmpq.push_back(eq[p]);
    end
    @(posedge clk); #1;
    drive(idle);
  endtask
  task automatic chk_reset();
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 0);
    chk("rst_mem_own", bus.mem_own, 1);
    chk("rst_core_start", bus.core_start, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timed_out", bus.timed_out, 0);
    chk("rst_run_cycles", bus.run_cycles, 0);
    chk("rst_mem_addr", bus.mem_addr, LB);
  endtask
  task automatic chk_load_image();
    for (int b = 0; b < LL; b++) chk("mem_image", mem[LB + b], 17 * (b + 1));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.go = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.core_done = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;
    build(1, 0, 0, 8'd0, 0, 0, 10);
    chk("trace_len_done10", eq.size(), 21);
    play(sq.size());
    @(negedge clk);
    chk("rc_done10", bus.run_cycles, 10);
    chk("to_done10", bus.timed_out, 0);
    chk_load_image();
    build(0, 30, 30, 8'd0, 0, 0, 0);
    play(sq.size());
    @(negedge clk);
    chk("rc_timeout", bus.run_cycles, 20);
    chk("to_timeout", bus.timed_out, 1);
    build(0, 0, 0, 8'b0000_1001, 1, 0, 5);
    chk("trace_len_stall", eq.size(), 1 + LL + SC + 5 + 4 + 2);
    play(sq.size());
    build(0, 0, 0, 8'd0, 0, 1, 2);
    play(sq.size());
    @(negedge clk);
    chk("rc_early2", bus.run_cycles, 2);
    build(0, 0, 0, 8'd0, 0, 1, 5);
    play(sq.size());
    @(negedge clk);
    chk("rc_early5", bus.run_cycles, 5);
    build(0, 0, 0, 8'd0, 0, 0, 20);
    play(sq.size());
    @(negedge clk);
    chk("to_done_at_limit", bus.timed_out, 0);
    build(1, 0, 0, 8'd0, 0, 0, 10);
    play(3);
    #1 rst_n = 1'b0;
    #1 chk_reset();
    last_rc = '0;
    last_to = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    build(1, 0, 0, 8'd0, 0, 0, 7);
    play(sq.size());
    @(negedge clk);
    chk("rc_after_reset", bus.run_cycles, 7);
    chk_load_image();
    repeat (40) begin
      build(0, $urandom_range(50), $urandom_range(50), 8'd0, 0, 1'($urandom_range(1)), $urandom_range(24));
      play(sq.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
